// File: rtl/ad9764_pkg.sv
// Shared definitions for the AD9764 DAC output block: register map,
// CTRL bit positions, sequencer states and STATUS field offsets.
package ad9764_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_DIV    = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_UNDR_CLR = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } dac_state_t;

   localparam int STATUS_EMPTY = 0;
   localparam int STATUS_FULL  = 1;
   localparam int STATUS_STATE = 2;
   localparam int STATUS_LEVEL = 8;

endpackage

// File: rtl/ad9764_dac_out_fifo.sv
// First-word-fall-through sample FIFO: dout shows the head entry so the
// sequencer can register it in the same cycle it pops.
module dac_sample_fifo #(
   parameter int DATA_W     = 14,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic                        push,
   input  logic [DATA_W-1:0]           din,
   input  logic                        pop,
   output logic [DATA_W-1:0]           dout,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [AW:0]       r_level;
   logic [AW:0]       w_levelNext;
   logic              r_full;
   logic              r_empty;
   logic              w_doPush;
   logic              w_doPop;

   // Both flags are registered, so a push can never sneak into a full FIFO
   // and a pop of an empty FIFO is simply ignored here.
   assign w_doPush = push & ~r_full;
   assign w_doPop  = pop & ~r_empty;

   always_comb begin
      w_levelNext = r_level;
      if (w_doPush && !w_doPop) begin
         w_levelNext = r_level + LVL_ONE;
      end else if (!w_doPush && w_doPop) begin
         w_levelNext = r_level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
         r_level <= w_levelNext;
         r_full  <= (w_levelNext == DEPTH_L);
         r_empty <= (w_levelNext == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= din;
   end

   assign dout  = r_mem[r_rdPtr];
   assign full  = r_full;
   assign empty = r_empty;
   assign level = r_level;

endmodule

// File: rtl/ad9764_dac_out.sv
// Avalon-MM fed DAC driver: host pushes samples into a FIFO, a rate divider
// pops one per output period and generates a mid-period DAC latch clock.
module ad9764_dac_out
   import ad9764_pkg::*;
#(
   parameter int                 DATA_W      = 14,
   parameter int                 FIFO_DEPTH  = 16,
   parameter int                 START_LEVEL = 8,
   parameter int                 DIV_RESET   = 3,
   parameter logic [DATA_W-1:0]  MIDSCALE    = 14'h2000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic [1:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic              dac_clk,
   output logic [DATA_W-1:0] dac_data
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);

   dac_state_t        r_state;
   dac_state_t        w_stateNext;
   logic              r_enable;
   logic              r_underrun;
   logic [15:0]       r_div;
   logic [15:0]       r_divCur;
   logic [15:0]       r_cnt;
   logic [15:0]       w_divNext;
   logic [15:0]       w_divCurNext;
   logic [15:0]       w_cntNext;
   logic [16:0]       w_halfNext;
   logic              w_dacClkNext;
   logic [DATA_W-1:0] r_dacData;
   logic              r_dacClk;
   logic [31:0]       r_readData;
   logic [31:0]       w_readMux;
   logic              w_pop;
   logic              w_flush;
   logic              w_underrunSet;
   logic              w_dataWr;
   logic              w_ctrlWr;
   logic              w_divWr;
   logic              w_push;
   logic [DATA_W-1:0] w_fifoDout;
   logic              w_full;
   logic              w_empty;
   logic [LW-1:0]     w_level;
   logic [7:0]        w_level8;
   logic              w_unused;

   assign w_dataWr    = chipselect & write & (address == ADDR_DATA);
   assign w_ctrlWr    = chipselect & write & (address == ADDR_CTRL);
   assign w_divWr     = chipselect & write & (address == ADDR_DIV);
   assign w_push      = w_dataWr & ~w_full;
   assign waitrequest = w_dataWr & w_full;
   assign w_level8    = 8'(w_level);
   assign w_unused    = ^writedata[31:16];

   dac_sample_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .flush  (w_flush),
      .push   (w_push),
      .din    (writedata[DATA_W-1:0]),
      .pop    (w_pop),
      .dout   (w_fifoDout),
      .full   (w_full),
      .empty  (w_empty),
      .level  (w_level)
   );

   // A zero divider would leave no room for a clock edge, so it becomes 1.
   always_comb begin
      w_divNext = r_div;
      if (w_divWr) begin
         w_divNext = (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext   = r_state;
      w_pop         = 1'b0;
      w_flush       = 1'b0;
      w_underrunSet = 1'b0;
      w_cntNext     = r_cnt;
      w_divCurNext  = r_divCur;
      case (r_state)
         IDLE: begin
            w_cntNext    = 16'd0;
            w_divCurNext = w_divNext;
            if (r_enable) w_stateNext = PRIME;
         end
         PRIME: begin
            w_cntNext    = 16'd0;
            w_divCurNext = w_divNext;
            if (!r_enable) begin
               w_stateNext = IDLE;
               w_flush     = 1'b1;
            end else if (w_level >= START_LVL) begin
               w_stateNext = RUN;
               w_pop       = 1'b1;
            end
         end
         RUN: begin
            if (!r_enable) begin
               w_stateNext = IDLE;
               w_flush     = 1'b1;
               w_cntNext   = 16'd0;
            end else if (r_cnt == r_divCur) begin
               // Period boundary: a pending DIV write takes over from here.
               w_cntNext    = 16'd0;
               w_divCurNext = r_div;
               if (w_empty) w_underrunSet = 1'b1;
               else         w_pop         = 1'b1;
            end else begin
               w_cntNext = r_cnt + 16'd1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_flush     = 1'b1;
            w_cntNext   = 16'd0;
         end
      endcase
   end

   assign w_halfNext   = ({1'b0, w_divCurNext} + 17'd1) >> 1;
   assign w_dacClkNext = (w_stateNext == RUN) && ({1'b0, w_cntNext} >= w_halfNext);

   always_comb begin
      w_readMux = 32'd0;
      case (address)
         ADDR_CTRL:   w_readMux = {30'd0, r_underrun, r_enable};
         ADDR_DIV:    w_readMux = {16'd0, r_div};
         ADDR_STATUS: w_readMux = {16'd0, w_level8, 4'd0, r_state, w_full, w_empty};
         default:     w_readMux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_enable   <= 1'b0;
         r_underrun <= 1'b0;
         r_div      <= 16'(DIV_RESET);
         r_divCur   <= 16'(DIV_RESET);
         r_cnt      <= 16'd0;
         r_dacData  <= MIDSCALE;
         r_dacClk   <= 1'b0;
         r_readData <= 32'd0;
      end else begin
         r_div    <= w_divNext;
         r_divCur <= w_divCurNext;
         r_cnt    <= w_cntNext;
         r_dacClk <= w_dacClkNext;
         if (w_ctrlWr) r_enable <= writedata[CTRL_EN];
         if (w_underrunSet) begin
            r_underrun <= 1'b1;
         end else if (w_ctrlWr && writedata[CTRL_UNDR_CLR]) begin
            r_underrun <= 1'b0;
         end
         if (w_flush)    r_dacData <= MIDSCALE;
         else if (w_pop) r_dacData <= w_fifoDout;
         if (chipselect && read) r_readData <= w_readMux;
      end
   end

   assign readdata = r_readData;
   assign dac_clk  = r_dacClk;
   assign dac_data = r_dacData;

endmodule

// File: tb/tb_ad9764_dac_out.sv
// Scoreboard bench for ad9764_dac_out: every accepted DATA write queues an
// expected sample that is matched when dac_data changes.
module tb_ad9764_dac_out;
   import ad9764_pkg::*;

   localparam logic [13:0] MID = 14'h2000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        chipselect;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        dac_clk;
   logic [13:0] dac_data;

   int total = 0;
   int bad   = 0;

   logic [13:0] q[$];
   int          cycle      = 0;
   int          lastChange = 0;
   int          lastGap    = 0;
   int          expPeriod  = 0;
   int          expRise    = 0;
   bit          skipNext   = 1'b1;
   logic [13:0] prevData   = MID;
   logic        prevClk    = 1'b0;

   always #5 clk = ~clk;

   ad9764_dac_out dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write      (write),
      .writedata  (writedata),
      .read       (read),
      .readdata   (readdata),
      .waitrequest(waitrequest),
      .dac_clk    (dac_clk),
      .dac_data   (dac_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on each new sample and checks the
   // sample spacing and the latch-clock rise position when enabled.
   always @(negedge clk) begin
      cycle++;
      if (reset_n === 1'b1 && dac_data != prevData) begin
         if (dac_data != MID) begin
            if (q.size() == 0) begin
               checkOutput("sbUnderflow", 32'(q.size()), 32'd1);
            end else begin
               checkOutput("sample", {18'd0, dac_data}, {18'd0, q.pop_front()});
            end
            lastGap = cycle - lastChange;
            if (!skipNext && expPeriod != 0) checkOutput("period", lastGap, expPeriod);
            skipNext   = 1'b0;
            lastChange = cycle;
         end
         prevData = dac_data;
      end
      if (reset_n === 1'b1 && dac_clk && !prevClk && !skipNext && expRise != 0) begin
         checkOutput("rise", cycle - lastChange, expRise);
      end
      prevClk = dac_clk;
   end

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d, output int waits);
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
      waits      = 0;
      #1;
      while (waitrequest && waits < 200) begin
         @(negedge clk);
         #1;
         waits++;
      end
      checkOutput("wrTimeout", {31'd0, waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      int w;
      busWrite(a, d, w);
   endtask

   task automatic pushSample(input logic [13:0] v);
      applyStimulus(ADDR_DATA, {18'h3FFFF, v});
      q.push_back(v);
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
      d          = readdata;
   endtask

   task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      busRead(a, d);
      checkOutput(tag, d, exp);
   endtask

   task automatic waitQueue(input int target, input int limit);
      int n = 0;
      while (q.size() > target && n < limit) begin
         @(posedge clk);
         n++;
      end
      checkOutput("queueWait", 32'(q.size()), 32'(target));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waits;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      address    = 2'd0;
      writedata  = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      checkOutput("rstData", {18'd0, dac_data}, {18'd0, MID});
      checkOutput("rstClk", {31'd0, dac_clk}, 32'd0);
      checkOutput("rstWait", {31'd0, waitrequest}, 32'd0);
      readCheck("rstStatus", ADDR_STATUS, 32'h0000_0001);
      repeat (3) @(posedge clk);
      #1 checkOutput("readHold", readdata, 32'h0000_0001);
      readCheck("rstCtrl", ADDR_CTRL, 32'h0);
      readCheck("rstDiv", ADDR_DIV, 32'd3);

      // Priming and steady output at DIV=3, then underrun
      applyStimulus(ADDR_DIV, 32'd3);
      for (int i = 1; i <= 8; i++) pushSample(14'(i));
      readCheck("primeStatus", ADDR_STATUS, 32'h0000_0800);
      expPeriod = 4;
      expRise   = 2;
      skipNext  = 1'b1;
      applyStimulus(ADDR_CTRL, 32'h1);
      waitQueue(0, 200);
      expPeriod = 0;
      expRise   = 0;
      repeat (10) @(posedge clk);
      #1 checkOutput("holdLast", {18'd0, dac_data}, 32'd8);
      readCheck("undrCtrl", ADDR_CTRL, 32'h3);
      readCheck("undrStatus", ADDR_STATUS, 32'h0000_0009);

      // DIV=0 stored as 1, refill while running, clear underrun
      applyStimulus(ADDR_DIV, 32'd0);
      readCheck("div0", ADDR_DIV, 32'd1);
      expPeriod = 2;
      expRise   = 1;
      skipNext  = 1'b1;
      for (int i = 0; i < 12; i++) pushSample(14'h100 + 14'(i));
      applyStimulus(ADDR_CTRL, 32'h3);
      readCheck("undrClr", ADDR_CTRL, 32'h1);
      waitQueue(0, 200);
      expPeriod = 0;
      expRise   = 0;

      // Disable mid-run at level 5
      applyStimulus(ADDR_CTRL, 32'h0);
      q.delete();
      skipNext = 1'b1;
      applyStimulus(ADDR_DIV, 32'd3);
      for (int i = 0; i < 8; i++) pushSample(14'h0A0 + 14'(i));
      expPeriod = 4;
      expRise   = 2;
      skipNext  = 1'b1;
      applyStimulus(ADDR_CTRL, 32'h1);
      waitQueue(5, 200);
      applyStimulus(ADDR_CTRL, 32'h0);
      q.delete();
      expPeriod = 0;
      expRise   = 0;
      skipNext  = 1'b1;
      readCheck("disLevel5", ADDR_STATUS, 32'h0000_0508);
      checkOutput("disData", {18'd0, dac_data}, {18'd0, MID});
      checkOutput("disClk", {31'd0, dac_clk}, 32'd0);
      readCheck("disStatus", ADDR_STATUS, 32'h0000_0001);
      readCheck("undrKept", ADDR_CTRL, 32'h2);
      applyStimulus(ADDR_CTRL, 32'h2);
      readCheck("undrClrIdle", ADDR_CTRL, 32'h0);

      // Full FIFO stalls the 17th write until the first pop
      for (int i = 0; i < 16; i++) pushSample(14'h200 + 14'(i));
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = ADDR_DATA;
      writedata  = 32'h0000_02FF;
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput("stallWr", {31'd0, waitrequest}, 32'd1);
         @(negedge clk);
      end
      chipselect = 1'b0;
      write      = 1'b0;
      readCheck("fullStatus", ADDR_STATUS, 32'h0000_1002);
      applyStimulus(ADDR_DIV, 32'd0);
      readCheck("div0b", ADDR_DIV, 32'd1);
      expPeriod = 2;
      expRise   = 1;
      skipNext  = 1'b1;
      applyStimulus(ADDR_CTRL, 32'h1);
      busWrite(ADDR_DATA, 32'h0000_02FF, waits);
      q.push_back(14'h2FF);
      checkOutput("stallWaits", waits, 32'd2);
      waitQueue(0, 400);
      expPeriod = 0;
      expRise   = 0;

      // DIV 3 -> 7 mid-run: new period begins at the following wrap
      applyStimulus(ADDR_CTRL, 32'h0);
      q.delete();
      skipNext = 1'b1;
      applyStimulus(ADDR_DIV, 32'd3);
      for (int i = 0; i < 16; i++) pushSample(14'h300 + 14'(i));
      expPeriod = 4;
      expRise   = 2;
      skipNext  = 1'b1;
      applyStimulus(ADDR_CTRL, 32'h1);
      waitQueue(13, 300);
      waitQueue(12, 20);
      expPeriod = 0;
      expRise   = 0;
      applyStimulus(ADDR_DIV, 32'd7);
      waitQueue(11, 20);
      checkOutput("gapOld", lastGap, 32'd4);
      waitQueue(10, 20);
      checkOutput("gapNew", lastGap, 32'd8);
      expPeriod = 8;
      expRise   = 4;
      waitQueue(0, 200);
      expPeriod = 0;
      expRise   = 0;
      readCheck("div7", ADDR_DIV, 32'd7);

      applyStimulus(ADDR_CTRL, 32'h0);
      q.delete();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
